// File: rtl/nco_pkg.sv
// Shared constants and helpers for the NCO phase path and its consumers.
package nco_pkg;

    localparam int NCO_AW = 32;
    localparam int NCO_PW = 12;

    // Quarter turn (+90 degrees) expressed in output-phase LSBs.
    function automatic longint unsigned quarter_turn(input int pw);
        return 64'd1 << (pw - 2);
    endfunction

    // Half an output LSB expressed in accumulator LSBs; added before truncation to round.
    function automatic longint unsigned round_half(input int aw, input int pw);
        return 64'd1 << (aw - pw - 1);
    endfunction

endpackage

// File: rtl/nco_phase_accumulator_if.sv
// Control and phase-output bundle of the NCO phase accumulator.
interface nco_phase_accumulator_if
    import nco_pkg::*;
#(
    parameter int AW = NCO_AW,
    parameter int PW = NCO_PW
);

    logic          i_ce;
    logic          i_ftw_wr;
    logic [AW-1:0] i_ftw;
    logic          i_poff_wr;
    logic [AW-1:0] i_poff;
    logic          i_sync;

    logic          o_ce;
    logic [PW-1:0] o_phase_i;
    logic [PW-1:0] o_phase_q;
    logic          o_wrap;

    modport master (
        output i_ce, i_ftw_wr, i_ftw, i_poff_wr, i_poff, i_sync,
        input  o_ce, o_phase_i, o_phase_q, o_wrap
    );

    modport slave (
        input  i_ce, i_ftw_wr, i_ftw, i_poff_wr, i_poff, i_sync,
        output o_ce, o_phase_i, o_phase_q, o_wrap
    );

endinterface

// File: rtl/nco_round_trunc.sv
// Combinational phase offset, round-half-up and truncate to the output phase width,
// plus the quadrature (+90 degree) companion word.
module nco_round_trunc
    import nco_pkg::*;
#(
    parameter int AW = NCO_AW,
    parameter int PW = NCO_PW
) (
    input  logic [AW-1:0] acc,
    input  logic [AW-1:0] poff,
    output logic [PW-1:0] phase_i,
    output logic [PW-1:0] phase_q
);

    localparam logic [AW-1:0] ROUND_HALF = AW'(round_half(AW, PW));
    localparam logic [PW-1:0] QUARTER    = PW'(quarter_turn(PW));

    logic [AW-1:0] sum;

    // Everything wraps modulo 2^AW, so a rounding carry past the top bit folds back to phase 0.
    assign sum     = acc + poff + ROUND_HALF;
    assign phase_i = sum[AW-1 -: PW];
    assign phase_q = phase_i + QUARTER;

endmodule

// File: rtl/nco_phase_accumulator.sv
// NCO phase generator: FTW accumulator (stage 1) followed by offset/round into
// registered I and Q phase words (stage 2). Feeds quarter_wave_sine_lookup.
module nco_phase_accumulator
    import nco_pkg::*;
#(
    parameter int AW = NCO_AW,
    parameter int PW = NCO_PW
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    nco_phase_accumulator_if.slave bus
);

    localparam logic [PW-1:0] QUARTER = PW'(quarter_turn(PW));

    logic [AW-1:0] acc;
    logic [AW-1:0] ftw_reg;
    logic [AW-1:0] poff_reg;
    logic          ce_d1;
    logic          wrap_d1;
    logic [AW:0]   acc_sum;

    logic          ce_q;
    logic          wrap_q;
    logic [PW-1:0] phase_i_q;
    logic [PW-1:0] phase_q_q;
    logic [PW-1:0] rt_phase_i;
    logic [PW-1:0] rt_phase_q;

    assign acc_sum = {1'b0, acc} + {1'b0, ftw_reg};

    // Stage 1: tuning-word loads and the phase accumulator.
    always_ff @(posedge i_clk) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values,
        // which is what makes a same-cycle FTW write leave this cycle's step untouched.
        if (i_reset) begin
            acc      <= '0;
            ftw_reg  <= '0;
            poff_reg <= '0;
            ce_d1    <= 1'b0;
            wrap_d1  <= 1'b0;
        end else begin
            if (bus.i_ftw_wr) begin
                ftw_reg <= bus.i_ftw;
            end
            if (bus.i_poff_wr) begin
                poff_reg <= bus.i_poff;
            end
            // Sync wins over advance but still emits a sample (ce_d1 follows i_ce).
            if (bus.i_sync) begin
                acc     <= '0;
                wrap_d1 <= 1'b0;
            end else if (bus.i_ce) begin
                {wrap_d1, acc} <= acc_sum;
            end
            ce_d1 <= bus.i_ce;
        end
    end

    nco_round_trunc #(
        .AW(AW),
        .PW(PW)
    ) u_round_trunc (
        .acc     (acc),
        .poff    (poff_reg),
        .phase_i (rt_phase_i),
        .phase_q (rt_phase_q)
    );

    // Stage 2: register the rounded phase words; they hold between valid samples.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            ce_q      <= 1'b0;
            wrap_q    <= 1'b0;
            phase_i_q <= '0;
            phase_q_q <= QUARTER;
        end else begin
            ce_q <= ce_d1;
            if (ce_d1) begin
                phase_i_q <= rt_phase_i;
                phase_q_q <= rt_phase_q;
                wrap_q    <= wrap_d1;
            end else begin
                wrap_q    <= 1'b0;
            end
        end
    end

    assign bus.o_ce      = ce_q;
    assign bus.o_wrap    = wrap_q;
    assign bus.o_phase_i = phase_i_q;
    assign bus.o_phase_q = phase_q_q;

endmodule

// File: tb/tb_nco_phase_accumulator.sv
// Self-checking bench for nco_phase_accumulator: directed test-plan scenarios plus
// randomized traffic, all compared against a sample-level arithmetic reference model.
module tb_nco_phase_accumulator;
    import nco_pkg::*;

    localparam int AW = 32;
    localparam int PW = 12;

    logic i_clk = 1'b0;
    logic i_reset;

    always #5 i_clk = ~i_clk;

    nco_phase_accumulator_if #(.AW(AW), .PW(PW)) bus ();

    nco_phase_accumulator #(.AW(AW), .PW(PW)) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .bus     (bus)
    );

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: turns of phase as plain modular integers.
    bit [31:0] m_acc, m_ftw, m_poff;
    bit        p_valid, p_wrap;
    bit [31:0] p_acc;
    bit        e_ce, e_wrap;
    bit [11:0] e_pi, e_pq;

    task automatic model_edge();
        bit [32:0] sum;
        bit [31:0] s;
        bit        w;
        if (i_reset) begin
            m_acc = 0; m_ftw = 0; m_poff = 0;
            p_valid = 0; p_acc = 0; p_wrap = 0;
            e_ce = 0; e_wrap = 0; e_pi = 0; e_pq = 12'd1024;
        end else begin
            // Emit the sample captured on the previous edge.
            e_ce = p_valid;
            if (p_valid) begin
                s      = p_acc + m_poff + 32'h0008_0000;
                e_pi   = 12'(s / 32'h0010_0000);
                e_pq   = 12'((32'(e_pi) + 1024) % 4096);
                e_wrap = p_wrap;
            end else begin
                e_wrap = 0;
            end
            w = 0;
            if (bus.i_sync) begin
                m_acc = 0;
            end else if (bus.i_ce) begin
                sum   = 33'(m_acc) + 33'(m_ftw);
                m_acc = 32'(sum % 33'h1_0000_0000);
                w     = (sum >= 33'h1_0000_0000);
            end
            p_valid = bus.i_ce;
            p_acc   = m_acc;
            p_wrap  = w;
            if (bus.i_ftw_wr)  m_ftw  = bus.i_ftw;
            if (bus.i_poff_wr) m_poff = bus.i_poff;
        end
    endtask

    string phase_name = "init";

    task automatic cycle();
        @(posedge i_clk);
        model_edge();
        @(negedge i_clk);
        check({phase_name, ".o_ce"},      64'(bus.o_ce),      64'(e_ce));
        check({phase_name, ".o_wrap"},    64'(bus.o_wrap),    64'(e_wrap));
        check({phase_name, ".o_phase_i"}, 64'(bus.o_phase_i), 64'(e_pi));
        check({phase_name, ".o_phase_q"}, 64'(bus.o_phase_q), 64'(e_pq));
    endtask

    task automatic clear_strobes();
        bus.i_ftw_wr  = 0;
        bus.i_poff_wr = 0;
        bus.i_sync    = 0;
    endtask

    int wraps;
    logic [11:0] p0;
    logic [11:0] round_seq [5];
    bit          gate_pat  [4];

    initial begin
        round_seq = '{12'd1, 12'd1, 12'd2, 12'd2, 12'd3};
        gate_pat  = '{1'b1, 1'b0, 1'b0, 1'b1};
        i_reset       = 1;
        bus.i_ce      = 0;
        bus.i_ftw     = 0;
        bus.i_poff    = 0;
        clear_strobes();
        @(negedge i_clk);

        // Reset state
        phase_name = "reset";
        cycle();
        cycle();
        check("reset_phase_q", 64'(bus.o_phase_q), 64'd1024);
        check("reset_phase_i", 64'(bus.o_phase_i), 64'd0);
        check("reset_ce",      64'(bus.o_ce),      64'd0);
        i_reset = 0;

        // Basic ramp, latency and wrap
        phase_name = "ramp";
        bus.i_ftw_wr = 1; bus.i_ftw = 32'h0010_0000;
        cycle();
        clear_strobes();
        bus.i_ce = 1;
        cycle();
        check("ramp_latency_low", 64'(bus.o_ce), 64'd0);
        cycle();
        check("ramp_first_ce", 64'(bus.o_ce), 64'd1);
        check("ramp_first_phase", 64'(bus.o_phase_i), 64'd1);
        wraps = 0;
        for (int i = 0; i < 4100; i++) begin
            cycle();
            if (bus.o_wrap === 1'b1) begin
                wraps++;
                check("ramp_wrap_at_zero", 64'(bus.o_phase_i), 64'd0);
            end
        end
        check("ramp_wrap_count", 64'(wraps), 64'd1);

        // Offset with DC tuning word
        phase_name = "offset";
        bus.i_ftw_wr = 1;  bus.i_ftw = 0;
        bus.i_poff_wr = 1; bus.i_poff = 32'h4000_0000;
        bus.i_sync = 1;
        cycle();
        clear_strobes();
        wraps = 0;
        for (int i = 0; i < 12; i++) begin
            cycle();
            if (bus.o_wrap === 1'b1) wraps++;
        end
        check("offset_phase_i", 64'(bus.o_phase_i), 64'd1024);
        check("offset_phase_q", 64'(bus.o_phase_q), 64'd2048);
        check("offset_no_wrap", 64'(wraps), 64'd0);

        // Rounding of a half-LSB step
        phase_name = "round";
        bus.i_ftw_wr = 1;  bus.i_ftw = 32'h0008_0000;
        bus.i_poff_wr = 1; bus.i_poff = 0;
        bus.i_sync = 1;
        cycle();
        clear_strobes();
        cycle();
        check("round_sync_sample", 64'(bus.o_phase_i), 64'd0);
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("round_seq", 64'(bus.o_phase_i), 64'(round_seq[i]));
        end

        // Clock-enable gating
        phase_name = "ce_gate";
        bus.i_ftw_wr = 1; bus.i_ftw = 32'h0010_0000;
        bus.i_sync = 1;
        cycle();
        clear_strobes();
        for (int i = 0; i < 16; i++) begin
            bus.i_ce = gate_pat[i % 4];
            cycle();
        end

        // Sync mid-ramp with i_ce high
        phase_name = "sync";
        bus.i_ce = 1;
        repeat (5) cycle();
        bus.i_sync = 1;
        cycle();
        bus.i_sync = 0;
        cycle();
        check("sync_phase_zero", 64'(bus.o_phase_i), 64'd0);
        cycle();
        check("sync_phase_one", 64'(bus.o_phase_i), 64'd1);

        // Reset mid-ramp flushes the pipeline
        phase_name = "mid_reset";
        repeat (3) cycle();
        i_reset = 1;
        cycle();
        check("midrst_phase_q", 64'(bus.o_phase_q), 64'd1024);
        check("midrst_phase_i", 64'(bus.o_phase_i), 64'd0);
        i_reset = 0;
        cycle();
        check("midrst_ce_low", 64'(bus.o_ce), 64'd0);
        cycle();
        check("midrst_ce_back", 64'(bus.o_ce), 64'd1);

        // FTW update while advancing
        phase_name = "ftw_update";
        bus.i_ftw_wr = 1; bus.i_ftw = 32'h0010_0000;
        bus.i_sync = 1;
        cycle();
        clear_strobes();
        repeat (4) cycle();
        bus.i_ftw_wr = 1; bus.i_ftw = 32'h0020_0000;
        cycle();
        p0 = bus.o_phase_i;
        bus.i_ftw_wr = 0;
        cycle();
        check("ftw_old_step", 64'(bus.o_phase_i), 64'(12'(p0 + 12'd1)));
        cycle();
        check("ftw_new_step", 64'(bus.o_phase_i), 64'(12'(p0 + 12'd3)));

        // Randomized traffic
        phase_name = "random";
        for (int i = 0; i < 3000; i++) begin
            bus.i_ce      = ($urandom_range(0, 3) != 0);
            bus.i_sync    = ($urandom_range(0, 63) == 0);
            bus.i_ftw_wr  = ($urandom_range(0, 31) == 0);
            bus.i_ftw     = ($urandom_range(0, 1) == 0) ? $urandom() : ($urandom() & 32'h00FF_FFFF);
            bus.i_poff_wr = ($urandom_range(0, 31) == 0);
            bus.i_poff    = $urandom();
            i_reset       = ($urandom_range(0, 499) == 0);
            cycle();
        end
        i_reset = 0;
        clear_strobes();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
